// File: rtl/param_deserializer_if.sv
// rtl/param_deserializer_if.sv - serial input, FIFO output and status bundle for param_deserializer
interface param_deserializer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                         data_in;
    logic                         write_in;
    logic                         ack_in;
    logic [WIDTH-1:0]             data_out;
    logic                         data_ready;
    logic                         status_out;
    logic [$clog2(DEPTH+1)-1:0]   count_out;
    logic                         parity_err;

    modport master (
        output data_in, write_in, ack_in,
        input  data_out, data_ready, status_out, count_out, parity_err
    );

    modport slave (
        input  data_in, write_in, ack_in,
        output data_out, data_ready, status_out, count_out, parity_err
    );
endinterface

// File: rtl/param_deserializer.sv
// rtl/param_deserializer.sv - serial-to-parallel deserializer feeding an output FIFO
// Optional even-parity framing when DESER_PARITY_EN is defined.
module param_deserializer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                clock_100,
    input  logic                reset,
    param_deserializer_if.slave bus
);

`ifdef DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW   = $clog2(FRAME);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_status;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_parity_err;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;

    logic             w_accept;
    logic             w_last;
    logic             w_par_ok;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_push_data;

    assign w_accept = bus.write_in && (r_state == RECV);
    assign w_full   = (r_count == CNTW'(DEPTH));
    assign w_pop    = bus.ack_in && (r_count != '0);

    assign w_shifted = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], bus.data_in}
                                        : {bus.data_in, r_shift[WIDTH-1:1]};

`ifdef DESER_PARITY_EN
    // The final frame bit is parity only; the data word is already complete in r_shift.
    assign w_last   = (r_bit_cnt == CW'(WIDTH));
    assign w_word   = r_shift;
    assign w_par_ok = ~(^r_shift ^ bus.data_in);
`else
    assign w_last   = (r_bit_cnt == CW'(WIDTH - 1));
    assign w_word   = w_shifted;
    assign w_par_ok = 1'b1;
`endif

    // A concurrent pop frees the slot, so a full FIFO still accepts a push on that edge.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = w_word;
        if (r_state == HOLD) begin
            w_push      = w_pop;
            w_push_data = r_shift;
        end else if (w_accept && w_last && w_par_ok && (!w_full || w_pop)) begin
            w_push = 1'b1;
        end
    end

    always_ff @(posedge clock_100) begin
        if (reset) begin
            r_state      <= RECV;
            r_status     <= 1'b1;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            case (r_state)
                RECV: begin
                    if (w_accept) begin
                        if (!w_last) begin
                            r_shift   <= w_shifted;
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end else begin
                            r_bit_cnt <= '0;
                            r_shift   <= w_word;
                            if (!w_par_ok) begin
                                r_parity_err <= 1'b1;
                            end else if (w_full && !w_pop) begin
                                r_state  <= HOLD;
                                r_status <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_pop) begin
                        r_state  <= RECV;
                        r_status <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= RECV;
                    r_status <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock_100) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNTW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNTW'(1);
            end
        end
    end

    assign bus.data_out   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign bus.data_ready = (r_count != '0);
    assign bus.status_out = r_status;
    assign bus.count_out  = r_count;
`ifdef DESER_PARITY_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_deserializer.sv
// tb/tb_param_deserializer.sv - directed self-checking bench for param_deserializer (MSB-first and LSB-first instances)
module tb_param_deserializer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    param_deserializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    param_deserializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_lsb ();

    assign bus_lsb.data_in  = bus.data_in;
    assign bus_lsb.write_in = bus.write_in;
    assign bus_lsb.ack_in   = bus.ack_in;

    param_deserializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) dut (
        .clock_100 (clk),
        .reset     (rst),
        .bus       (bus)
    );

    param_deserializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_lsb (
        .clock_100 (clk),
        .reset     (rst),
        .bus       (bus_lsb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.write_in = 1'b1;
        bus.data_in  = b;
        tick();
        bus.write_in = 1'b0;
        bus.data_in  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
`ifdef DESER_PARITY_EN
        send_bit(^w);
`endif
    endtask

    task automatic pop();
        bus.ack_in = 1'b1;
        tick();
        bus.ack_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.write_in = 1'b1;
        tick();
        tick();
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", bus.data_ready); end
        checks++; if (bus.status_out !== 1'b1) begin errors++; $display("FAIL reset_status: got %b expected 1", bus.status_out); end
        checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count_out); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", bus.parity_err); end
        bus.write_in = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        send_word(8'hAD);
        checks++; if (bus.data_out !== 8'hAD) begin errors++; $display("FAIL basic_data_out: got %h expected ad", bus.data_out); end
        checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", bus.data_ready); end
        checks++; if (bus.count_out !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", bus.count_out); end
        pop();
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_after_ack: got %b expected 0", bus.data_ready); end
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL basic_data_after_ack: got %h expected 00", bus.data_out); end
    endtask

    task automatic test_lsb_first();
        send_word(8'hAD);
        checks++; if (bus_lsb.data_out !== 8'hB5) begin errors++; $display("FAIL lsb_data_out: got %h expected b5", bus_lsb.data_out); end
        checks++; if (bus.data_out !== 8'hAD) begin errors++; $display("FAIL lsb_msb_twin: got %h expected ad", bus.data_out); end
        pop();
    endtask

    task automatic test_ack_empty();
        pop();
        checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL ack_empty_count: got %0d expected 0", bus.count_out); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL ack_empty_ready: got %b expected 0", bus.data_ready); end
    endtask

    task automatic test_full_hold();
        logic [7:0] exp_q [4];
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        checks++; if (bus.count_out !== 3'd4) begin errors++; $display("FAIL full_count4: got %0d expected 4", bus.count_out); end
        checks++; if (bus.status_out !== 1'b1) begin errors++; $display("FAIL full_status_before: got %b expected 1", bus.status_out); end
        send_word(8'h55);
        checks++; if (bus.count_out !== 3'd4) begin errors++; $display("FAIL hold_count: got %0d expected 4", bus.count_out); end
        checks++; if (bus.status_out !== 1'b0) begin errors++; $display("FAIL hold_status: got %b expected 0", bus.status_out); end
        send_word(8'hFF);
        checks++; if (bus.status_out !== 1'b0) begin errors++; $display("FAIL hold_status_ignored: got %b expected 0", bus.status_out); end
        checks++; if (bus.data_out !== 8'h11) begin errors++; $display("FAIL hold_head: got %h expected 11", bus.data_out); end
        pop();
        checks++; if (bus.data_out !== 8'h22) begin errors++; $display("FAIL hold_release_head: got %h expected 22", bus.data_out); end
        checks++; if (bus.status_out !== 1'b1) begin errors++; $display("FAIL hold_release_status: got %b expected 1", bus.status_out); end
        checks++; if (bus.count_out !== 3'd4) begin errors++; $display("FAIL hold_release_count: got %0d expected 4", bus.count_out); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.data_out !== exp_q[i]) begin errors++; $display("FAIL hold_drain_%0d: got %h expected %h", i, bus.data_out, exp_q[i]); end
            pop();
        end
        checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL hold_drained_count: got %0d expected 0", bus.count_out); end
        send_word(8'h96);
        checks++; if (bus.data_out !== 8'h96) begin errors++; $display("FAIL after_hold_word: got %h expected 96", bus.data_out); end
        checks++; if (bus.count_out !== 3'd1) begin errors++; $display("FAIL after_hold_count: got %0d expected 1", bus.count_out); end
        pop();
    endtask

    task automatic test_back_to_back();
        logic       last_bit;
        logic [7:0] w;
        logic [7:0] exp_q [4];
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
        w = 8'h55;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
`ifdef DESER_PARITY_EN
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
        last_bit = ^w;
`else
        for (int i = WIDTH - 1; i >= 1; i--) send_bit(w[i]);
        last_bit = w[0];
`endif
        bus.ack_in   = 1'b1;
        bus.write_in = 1'b1;
        bus.data_in  = last_bit;
        tick();
        bus.ack_in   = 1'b0;
        bus.write_in = 1'b0;
        bus.data_in  = 1'b0;
        checks++; if (bus.count_out !== 3'd4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", bus.count_out); end
        checks++; if (bus.status_out !== 1'b1) begin errors++; $display("FAIL b2b_status: got %b expected 1", bus.status_out); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.data_out !== exp_q[i]) begin errors++; $display("FAIL b2b_drain_%0d: got %h expected %h", i, bus.data_out, exp_q[i]); end
            pop();
        end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", bus.data_ready); end
    endtask

    task automatic test_reset_midword();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_word(8'h3C);
        checks++; if (bus.data_out !== 8'h3C) begin errors++; $display("FAIL midreset_data: got %h expected 3c", bus.data_out); end
        checks++; if (bus.count_out !== 3'd1) begin errors++; $display("FAIL midreset_count: got %0d expected 1", bus.count_out); end
        pop();
    endtask

`ifdef DESER_PARITY_EN
    task automatic test_parity();
        logic [7:0] w;
        w = 8'hAD;
        send_word(w);
        checks++; if (bus.count_out !== 3'd1) begin errors++; $display("FAIL parity_good_count: got %0d expected 1", bus.count_out); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL parity_good_err: got %b expected 0", bus.parity_err); end
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
        send_bit(1'b0);
        checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad_pulse: got %b expected 1", bus.parity_err); end
        checks++; if (bus.count_out !== 3'd1) begin errors++; $display("FAIL parity_bad_count: got %0d expected 1", bus.count_out); end
        tick();
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL parity_pulse_width: got %b expected 0", bus.parity_err); end
        pop();
        checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL parity_drain: got %0d expected 0", bus.count_out); end
    endtask
`else
    task automatic test_parity();
        send_word(8'hAD);
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL parity_disabled: got %b expected 0", bus.parity_err); end
        pop();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.data_in  = 1'b0;
        bus.write_in = 1'b0;
        bus.ack_in   = 1'b0;
        test_reset();
        test_basic();
        test_lsb_first();
        test_ack_empty();
        test_full_hold();
        test_back_to_back();
        test_reset_midword();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
